dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-requester arbiter sharing the single-port data memory of the machine.
- Requester 0 is the CPU load/store path; requester 1 is a debug/DMA port used by benches to preload and dump data segments.
- Performs round-robin grant, drives the memory command bus, and routes read data back to the issuing requester after a fixed memory latency.
- Sits between the datapath and data_memory.

Parameters:
- ADDR_W, 30, word-address width (byte address bits [31:2]).
- DATA_W, 32, data width.
- MEM_LAT, 1, memory read latency in cycles from command to mem_rdata valid; legal range 1..4.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req0 / req1  in  1  request; held with its fields stable until granted.
- we0 / we1  in  1  1 = write, 0 = read.
- addr0 / addr1  in  ADDR_W  word address.
- wdata0 / wdata1  in  DATA_W  write data.
- be0 / be1  in  DATA_W/8  byte enables for writes.
- gnt0 / gnt1  out  1  grant; the command is accepted in this cycle.
- rvalid0 / rvalid1  out  1  read data valid for that requester.
- rdata  out  DATA_W  read data, shared by both requesters; qualified by rvalid.
- mem_en  out  1  memory command strobe.
- mem_we  out  1  memory write.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_be  out  DATA_W/8  memory byte enables.
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after the read command.

Behaviour:
- Reset (asynchronous, reset=0):
  - rr_last = 1, so requester 0 wins the first contention.
  - Return pipeline cleared.
  - All gnt, rvalid and mem_* outputs = 0; rdata = 0.
- Grant is combinational from req and registered state:
  - Only one requester active → it is granted.
  - Both active → the one != rr_last is granted.
  - rr_last updates to the winner on the clock edge.
- Granted cycle:
  - mem_en = 1.
  - mem_we/addr/wdata/be = the winner's fields, muxed combinationally.
- Idle cycle (no request): mem_en = 0, mem_we = 0, other mem_* = 0.
- Throughput: one command per cycle, back-to-back. A lone requester is granted every cycle it requests.
- Sustained contention alternates strictly: 0, 1, 0, 1, ...
- Writes complete at grant; no rvalid is generated.
- Reads: a MEM_LAT-deep shift register carries {valid, id} per issued read.
  - At depth MEM_LAT: rvalid<id> = 1, rdata = mem_rdata, both in the same cycle.
  - Reads return in issue order. The two rvalids are never both 1.
- A requester may issue a new read before its previous rvalid; responses stay ordered.
- A request deasserted before grant is dropped silently (protocol violation, not flagged).
- Reset mid-operation: in-flight reads are discarded, no rvalid after reset release, rr_last returns to 1.
- With no request, rr_last is unchanged.

Optional Feature:
- Macro: DMEM_ARB_LOCK_EN.
- Defined:
  - Adds inputs lock0 and lock1.
  - If the granted requester has lock=1 in its grant cycle, the arbiter enters LOCKED(owner).
  - While LOCKED, only the owner can be granted; the other requester waits even if the owner is idle.
  - LOCKED is exited on the first cycle the owner presents lock=0; the grant in that cycle follows normal round-robin.
  - Reset clears LOCKED.
  - Purpose: atomic read-modify-write, e.g. ll/sc and debug RMW.
- Undefined:
  - No lock ports.
  - Pure round-robin as above.

Decomposition:
- Package dmem_arb_pkg:
  - typedef req_id_t (1 bit).
  - constants ID_CPU = 0, ID_DBG = 1.
  - constant MAX_MEM_LAT = 4.
  - typedef lock state enum {UNLOCKED, LOCKED}.
- Sub-module dmem_arb_rsp_pipe:
  - MEM_LAT-deep {valid, id} shift register with async active-low clear.
  - Produces rvalid0/rvalid1.
- The top level holds the grant logic, rr_last, the command mux and the lock FSM.

Test Plan:
- Reset, then req0 read addr 0x4000 alone (MEM_LAT = 1, memory preloaded 0x0000007B) → gnt0 same cycle, mem_addr = 0x4000, rvalid0 = 1 and rdata = 0x0000007B next cycle, rvalid1 = 0.
- req0 and req1 held high for 6 cycles after reset, both reads → grant order 0, 1, 0, 1, 0, 1; the rvalid sequence matches it one cycle later (MEM_LAT = 1) and MEM_LAT cycles later with MEM_LAT = 3.
- req1 write addr 0x4001, wdata 0x00000064, be 0xF, then req0 read 0x4001 the next cycle → mem_we = 1 in cycle 1; rdata = 0x00000064 with rvalid0.
- Three back-to-back reads issued with MEM_LAT = 3, then reset pulsed low for 1 cycle on the edge after the last read is issued → no rvalid after reset release; the next contention grants requester 0.
- Both requesters idle 5 cycles → mem_en = 0 throughout and rr_last unchanged; then req1 alone → gnt1 immediately.
- With DMEM_ARB_LOCK_EN: req1 granted with lock1 = 1 and req0 pending → req0 not granted for 4 locked req1 cycles; grant resumes alternation on the cycle lock1 = 0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-requester data-memory arbiter.
package dmem_arb_pkg;

  typedef logic req_id_t;

  localparam req_id_t ID_CPU = 1'b0;
  localparam req_id_t ID_DBG = 1'b1;

  localparam int unsigned MAX_MEM_LAT = 4;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

endpackage

// File: rtl/dmem_arb_rsp_pipe.sv
// Read-return tracker: carries {valid, id} of each issued read for MEM_LAT cycles
// and flags which requester owns the data arriving on mem_rdata.
module dmem_arb_rsp_pipe
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    issue_vld,
  input  req_id_t issue_id,
  output logic    rvalid0,
  output logic    rvalid1
);

  logic    [MEM_LAT-1:0] vld_q, vld_d;
  req_id_t [MEM_LAT-1:0] id_q,  id_d;

  always_comb begin
    vld_d    = vld_q;
    id_d     = id_q;
    vld_d[0] = issue_vld;
    id_d[0]  = issue_id;
    for (int unsigned i = 1; i < MEM_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      id_d[i]  = id_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      id_q  <= '0;
    end else begin
      vld_q <= vld_d;
      id_q  <= id_d;
    end
  end

  assign rvalid0 = vld_q[MEM_LAT-1] && (id_q[MEM_LAT-1] == ID_CPU);
  assign rvalid1 = vld_q[MEM_LAT-1] && (id_q[MEM_LAT-1] == ID_DBG);

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter for the single-port data memory (CPU port 0, debug/DMA port 1).
// Optional bus locking for atomic RMW is enabled with `define DMEM_ARB_LOCK_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 30,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req0,
  input  logic                req1,
  input  logic                we0,
  input  logic                we1,
  input  logic [ADDR_W-1:0]   addr0,
  input  logic [ADDR_W-1:0]   addr1,
  input  logic [DATA_W-1:0]   wdata0,
  input  logic [DATA_W-1:0]   wdata1,
  input  logic [DATA_W/8-1:0] be0,
  input  logic [DATA_W/8-1:0] be1,
`ifdef DMEM_ARB_LOCK_EN
  input  logic                lock0,
  input  logic                lock1,
`endif
  output logic                gnt0,
  output logic                gnt1,
  output logic                rvalid0,
  output logic                rvalid1,
  output logic [DATA_W-1:0]   rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata
);

  req_id_t rr_last_q, rr_last_d;

`ifdef DMEM_ARB_LOCK_EN
  lock_state_e lock_q, lock_d;
  req_id_t     owner_q, owner_d;
  logic        hold;
`endif

  // Grant selection; the lock is honoured only while the owner keeps its lock bit high.
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    rr_last_d = rr_last_q;
`ifdef DMEM_ARB_LOCK_EN
    hold    = (lock_q == LOCKED) && ((owner_q == ID_CPU) ? lock0 : lock1);
    lock_d  = UNLOCKED;
    owner_d = owner_q;
    if (hold) begin
      gnt0 = req0 && (owner_q == ID_CPU);
      gnt1 = req1 && (owner_q == ID_DBG);
    end else
`endif
    if (req0 && req1) begin
      gnt0 = (rr_last_q == ID_DBG);
      gnt1 = (rr_last_q == ID_CPU);
    end else begin
      gnt0 = req0;
      gnt1 = req1;
    end
    if (!reset) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
    if (gnt0) begin
      rr_last_d = ID_CPU;
    end else if (gnt1) begin
      rr_last_d = ID_DBG;
    end
`ifdef DMEM_ARB_LOCK_EN
    if (hold) begin
      lock_d = LOCKED;
    end
    if ((gnt0 && lock0) || (gnt1 && lock1)) begin
      lock_d  = LOCKED;
      owner_d = gnt1 ? ID_DBG : ID_CPU;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_last_q <= ID_DBG;
    end else begin
      rr_last_q <= rr_last_d;
    end
  end

`ifdef DMEM_ARB_LOCK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lock_q  <= UNLOCKED;
      owner_q <= ID_CPU;
    end else begin
      lock_q  <= lock_d;
      owner_q <= owner_d;
    end
  end
`endif

  // Command mux: winner's fields, all zero when idle.
  always_comb begin
    mem_en    = gnt0 | gnt1;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (gnt0) begin
      mem_we    = we0;
      mem_addr  = addr0;
      mem_wdata = wdata0;
      mem_be    = be0;
    end else if (gnt1) begin
      mem_we    = we1;
      mem_addr  = addr1;
      mem_wdata = wdata1;
      mem_be    = be1;
    end
  end

  dmem_arb_rsp_pipe #(
    .MEM_LAT (MEM_LAT)
  ) u_rsp_pipe (
    .clk       (clk),
    .rst_n     (reset),
    .issue_vld (mem_en & ~mem_we),
    .issue_id  (gnt1 ? ID_DBG : ID_CPU),
    .rvalid0   (rvalid0),
    .rvalid1   (rvalid1)
  );

  assign rdata = (rvalid0 | rvalid1) ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (MEM_LAT 1 and 3) share stimulus, each with its own memory.
module tb_dmem_arbiter;

  localparam int unsigned AW = 30;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, req0, req1, we0, we1, lock0, lock1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic [BW-1:0] be0, be1;

  logic          gnt0_a, gnt1_a, rvalid0_a, rvalid1_a, mem_en_a, mem_we_a;
  logic [DW-1:0] rdata_a, mem_wdata_a, mem_rdata_a;
  logic [AW-1:0] mem_addr_a;
  logic [BW-1:0] mem_be_a;
  logic          gnt0_b, gnt1_b, rvalid0_b, rvalid1_b, mem_en_b, mem_we_b;
  logic [DW-1:0] rdata_b, mem_wdata_b, mem_rdata_b;
  logic [AW-1:0] mem_addr_b;
  logic [BW-1:0] mem_be_b;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) u_dut_a (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1), .be0(be0), .be1(be1),
`ifdef DMEM_ARB_LOCK_EN
    .lock0(lock0), .lock1(lock1),
`endif
    .gnt0(gnt0_a), .gnt1(gnt1_a), .rvalid0(rvalid0_a), .rvalid1(rvalid1_a), .rdata(rdata_a),
    .mem_en(mem_en_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
    .mem_be(mem_be_a), .mem_rdata(mem_rdata_a)
  );

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3)) u_dut_b (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1), .be0(be0), .be1(be1),
`ifdef DMEM_ARB_LOCK_EN
    .lock0(lock0), .lock1(lock1),
`endif
    .gnt0(gnt0_b), .gnt1(gnt1_b), .rvalid0(rvalid0_b), .rvalid1(rvalid1_b), .rdata(rdata_b),
    .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .mem_be(mem_be_b), .mem_rdata(mem_rdata_b)
  );

  function automatic logic [DW-1:0] init_val(input int i);
    return (i == 0) ? 32'h0000_007B : DW'(32'hA500_0000 ^ (i * 32'h0101_0013));
  endfunction

  // Memories behind each DUT: preloaded on the first edge, reads return after the instance latency.
  bit            loaded = 1'b0;
  logic [DW-1:0] mem_a [64];
  logic [DW-1:0] mem_b [64];
  logic [DW-1:0] pa;
  logic [DW-1:0] pb [3];

  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 64; i++) begin
        mem_a[i] <= init_val(i);
        mem_b[i] <= init_val(i);
      end
      loaded <= 1'b1;
      pa     <= '0;
      for (int j = 0; j < 3; j++) pb[j] <= '0;
    end else begin
      pa    <= '0;
      pb[0] <= '0;
      pb[1] <= pb[0];
      pb[2] <= pb[1];
      if (mem_en_a) begin
        if (mem_we_a) begin
          for (int k = 0; k < 4; k++)
            if (mem_be_a[k]) mem_a[mem_addr_a[5:0]][8*k +: 8] <= mem_wdata_a[8*k +: 8];
        end else begin
          pa <= mem_a[mem_addr_a[5:0]];
        end
      end
      if (mem_en_b) begin
        if (mem_we_b) begin
          for (int k = 0; k < 4; k++)
            if (mem_be_b[k]) mem_b[mem_addr_b[5:0]][8*k +: 8] <= mem_wdata_b[8*k +: 8];
        end else begin
          pb[0] <= mem_b[mem_addr_b[5:0]];
        end
      end
    end
  end

  assign mem_rdata_a = pa;
  assign mem_rdata_b = pb[2];

  // Reference model state: last winner, lock owner (-1 = none), memory image, reads by issue cycle.
  int            rr, owner, cyc, last_w;
  logic [DW-1:0] ref_mem [64];
  bit            iss_v  [4096];
  bit            iss_id [4096];
  logic [DW-1:0] iss_d  [4096];
  int            n_chk, n_fail;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_rsp(input string tag, input int lat, input logic v0, input logic v1,
                         input logic [DW-1:0] d);
    int c;
    bit ev, eid;
    logic [DW-1:0] ed;
    c   = cyc - lat;
    ev  = (c >= 0) && iss_v[c % 4096];
    eid = (c >= 0) && iss_id[c % 4096];
    ed  = ev ? iss_d[c % 4096] : '0;
    chk({tag, "_rvalid0"}, 64'(v0), 64'(ev && !eid));
    chk({tag, "_rvalid1"}, 64'(v1), 64'(ev && eid));
    chk({tag, "_rdata"},   64'(d),  64'(ed));
  endtask

  // One clock cycle: predict, compare both instances, then advance the model on the edge.
  task automatic step();
    int w;
    bit hold, wr, lk;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [BW-1:0] b;
    #2;
    hold = (owner >= 0) && ((owner == 0) ? lock0 : lock1);
    if (hold)               w = ((owner == 0) ? req0 : req1) ? owner : -1;
    else if (req0 && req1)  w = (rr == 1) ? 0 : 1;
    else if (req0)          w = 0;
    else if (req1)          w = 1;
    else                    w = -1;
    wr = (w == 0) ? we0    : (w == 1) ? we1    : 1'b0;
    a  = (w == 0) ? addr0  : (w == 1) ? addr1  : '0;
    d  = (w == 0) ? wdata0 : (w == 1) ? wdata1 : '0;
    b  = (w == 0) ? be0    : (w == 1) ? be1    : '0;
    lk = (w == 0) ? lock0  : (w == 1) ? lock1  : 1'b0;
    chk("gnt0_a",      64'(gnt0_a),      64'(w == 0));
    chk("gnt1_a",      64'(gnt1_a),      64'(w == 1));
    chk("gnt0_b",      64'(gnt0_b),      64'(w == 0));
    chk("gnt1_b",      64'(gnt1_b),      64'(w == 1));
    chk("mem_en_a",    64'(mem_en_a),    64'(w >= 0));
    chk("mem_we_a",    64'(mem_we_a),    64'(wr));
    chk("mem_addr_a",  64'(mem_addr_a),  64'(a));
    chk("mem_wdata_a", 64'(mem_wdata_a), 64'(d));
    chk("mem_be_a",    64'(mem_be_a),    64'(b));
    chk("mem_addr_b",  64'(mem_addr_b),  64'(a));
    chk_rsp("a", 1, rvalid0_a, rvalid1_a, rdata_a);
    chk_rsp("b", 3, rvalid0_b, rvalid1_b, rdata_b);
    last_w = w;
    @(posedge clk);
    if (w >= 0) begin
      rr = w;
      if (wr) begin
        for (int k = 0; k < 4; k++)
          if (b[k]) ref_mem[a[5:0]][8*k +: 8] = d[8*k +: 8];
      end else begin
        iss_v[cyc % 4096]  = 1'b1;
        iss_id[cyc % 4096] = (w == 1);
        iss_d[cyc % 4096]  = ref_mem[a[5:0]];
      end
    end
    owner = (w >= 0 && lk) ? w : (hold ? owner : -1);
    cyc++;
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    for (int i = 0; i < 4096; i++) iss_v[i] = 1'b0;
    rr    = 1;
    owner = -1;
    repeat (n) begin
      #2;
      chk("rst_gnt_a",    64'({gnt0_a, gnt1_a}),       64'(0));
      chk("rst_gnt_b",    64'({gnt0_b, gnt1_b}),       64'(0));
      chk("rst_rvalid_a", 64'({rvalid0_a, rvalid1_a}), 64'(0));
      chk("rst_rvalid_b", 64'({rvalid0_b, rvalid1_b}), 64'(0));
      chk("rst_rdata_a",  64'(rdata_a),                64'(0));
      chk("rst_mem_a",    64'({mem_en_a, mem_we_a, mem_addr_a, mem_be_a}), 64'(0));
      chk("rst_mem_b",    64'({mem_en_b, mem_we_b, mem_addr_b, mem_be_b}), 64'(0));
      @(posedge clk);
      cyc++;
      #1;
    end
    reset = 1'b1;
  endtask

  task automatic idle(input int n);
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (n) step();
  endtask

  typedef struct {
    bit r0;
    bit r1;
    bit g0;
    bit g1;
  } vec_t;

  vec_t tbl [14];
  bit   p0, p1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    // Grant order from reset: first contention to 0, then strict alternation, idle keeps history.
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 1'b1, 1'b1, 1'b0};

    for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
    n_chk = 0; n_fail = 0; cyc = 0; last_w = -1; p0 = 1'b0; p1 = 1'b0;
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    lock0 = 1'b0; lock1 = 1'b0; addr0 = '0; addr1 = '0;
    wdata0 = '0; wdata1 = '0; be0 = '0; be1 = '0;
    #1;
    do_reset(3);

    // Lone read of 0x4000 returns the preloaded word one cycle later.
    req0 = 1'b1; we0 = 1'b0; addr0 = AW'(32'h4000);
    #1;
    chk("t1_gnt0",     64'(gnt0_a),     64'(1));
    chk("t1_mem_addr", 64'(mem_addr_a), 64'(32'h4000));
    step();
    req0 = 1'b0;
    #1;
    chk("t1_rvalid0", 64'(rvalid0_a), 64'(1));
    chk("t1_rvalid1", 64'(rvalid1_a), 64'(0));
    chk("t1_rdata",   64'(rdata_a),   64'(32'h7B));
    idle(4);

    do_reset(1);
    for (int i = 0; i < 14; i++) begin
      req0 = tbl[i].r0; req1 = tbl[i].r1; we0 = 1'b0; we1 = 1'b0;
      addr0 = AW'(32'h4000 + i); addr1 = AW'(32'h4020 + i);
      #1;
      chk("tbl_gnt0", 64'(gnt0_a), 64'(tbl[i].g0));
      chk("tbl_gnt1", 64'(gnt1_a), 64'(tbl[i].g1));
      step();
    end
    idle(4);

    // Write by port 1, read back by port 0 on the next cycle.
    req1 = 1'b1; we1 = 1'b1; addr1 = AW'(32'h4001); wdata1 = 32'h0000_0064; be1 = 4'hF;
    #1;
    chk("t3_gnt1",   64'(gnt1_a),   64'(1));
    chk("t3_mem_we", 64'(mem_we_a), 64'(1));
    step();
    req1 = 1'b0; req0 = 1'b1; we0 = 1'b0; addr0 = AW'(32'h4001);
    step();
    req0 = 1'b0;
    #1;
    chk("t3_rvalid0", 64'(rvalid0_a), 64'(1));
    chk("t3_rdata",   64'(rdata_a),   64'(32'h64));
    idle(4);

    // Three reads in flight, then a one-cycle reset: nothing may come back.
    for (int i = 0; i < 3; i++) begin
      req0 = 1'b1; we0 = 1'b0; addr0 = AW'(32'h4010 + i);
      step();
    end
    req0 = 1'b0;
    do_reset(1);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t4_no_rvalid_b", 64'({rvalid0_b, rvalid1_b}), 64'(0));
      step();
    end
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
    #1;
    chk("t4_first_gnt0", 64'(gnt0_a), 64'(1));
    step();

    // Idle keeps the round-robin history.
    idle(5);
    req0 = 1'b1; req1 = 1'b1;
    #1;
    chk("t5_gnt1_after_idle", 64'(gnt1_a), 64'(1));
    step();
    idle(5);
    req1 = 1'b1;
    #1;
    chk("t5_lone_gnt1", 64'(gnt1_a), 64'(1));
    step();
    idle(5);
    req0 = 1'b1; req1 = 1'b1;
    #1;
    chk("t5_gnt0_after_idle", 64'(gnt0_a), 64'(1));
    step();
    idle(4);

`ifdef DMEM_ARB_LOCK_EN
    do_reset(1);
    req1 = 1'b1; we1 = 1'b0; lock1 = 1'b1; addr1 = AW'(32'h4002);
    #1;
    chk("lk_first_gnt1", 64'(gnt1_a), 64'(1));
    step();
    req0 = 1'b1; we0 = 1'b0; addr0 = AW'(32'h4003);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("lk_gnt0_blocked", 64'(gnt0_a), 64'(0));
      chk("lk_gnt1_owner",   64'(gnt1_a), 64'(1));
      step();
    end
    req1 = 1'b0;
    #1;
    chk("lk_owner_idle_blocks", 64'({gnt0_a, gnt1_a}), 64'(0));
    step();
    req1 = 1'b1; lock1 = 1'b0;
    #1;
    chk("lk_release_gnt0", 64'(gnt0_a), 64'(1));
    step();
    #1;
    chk("lk_alternate_gnt1", 64'(gnt1_a), 64'(1));
    step();
    idle(4);
`endif

    // Random traffic: each port holds its request until granted.
    for (int n = 0; n < 1500; n++) begin
      if (!p0) begin
        if ($urandom_range(0, 9) < 6) begin
          p0 = 1'b1; req0 = 1'b1; we0 = 1'($urandom_range(0, 1));
          addr0 = AW'(32'h4000 + $urandom_range(0, 63));
          wdata0 = $urandom; be0 = BW'($urandom_range(0, 15));
        end else begin
          req0 = 1'b0;
        end
`ifdef DMEM_ARB_LOCK_EN
        lock0 = ($urandom_range(0, 3) == 0);
`endif
      end
      if (!p1) begin
        if ($urandom_range(0, 9) < 6) begin
          p1 = 1'b1; req1 = 1'b1; we1 = 1'($urandom_range(0, 1));
          addr1 = AW'(32'h4000 + $urandom_range(0, 63));
          wdata1 = $urandom; be1 = BW'($urandom_range(0, 15));
        end else begin
          req1 = 1'b0;
        end
`ifdef DMEM_ARB_LOCK_EN
        lock1 = ($urandom_range(0, 3) == 0);
`endif
      end
      step();
      if (last_w == 0) p0 = 1'b0;
      if (last_w == 1) p1 = 1'b0;
    end
    lock0 = 1'b0; lock1 = 1'b0;
    idle(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
